// File: rtl/oled_frame_arbiter.sv
// Round-robin owner of the single OLED display; ownership changes only on frame_begin.
// Grant, owner index and switch_pulse are registered one cycle after the frame_begin edge; pixel_data adds no latency.
// No backpressure: requests are levels sampled at frame_begin; a source that loses simply waits for a later frame.
module oled_frame_arbiter #(
  parameter int          N_SRC     = 4,
  parameter int          QUANTUM   = 30,
  parameter logic [15:0] BG_COLOUR = 16'h0000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     frame_begin,
  input  logic [N_SRC-1:0]         req,
  input  logic [16*N_SRC-1:0]      src_pixel,
  output logic [N_SRC-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(N_SRC)-1:0] active_idx,
  output logic                     switch_pulse,
  output logic [15:0]              pixel_data
);

  localparam int IDXW = $clog2(N_SRC);
  localparam int FW   = $clog2(QUANTUM + 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  logic [FW-1:0]   fcnt;
  logic [IDXW-1:0] rr_ptr;

  logic            win_vld;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] win_next_ptr;
  int              cand_idx;
  logic            own_req;
  logic            quantum_done;

  // Round-robin search starting at rr_ptr; walking offsets downward lets the smallest offset win.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = 0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      cand_idx = (int'(rr_ptr) + i) % N_SRC;
      if (req[IDXW'(cand_idx)]) begin
        win_vld = 1'b1;
        win_idx = IDXW'(cand_idx);
      end
    end
  end

  // Pointer to the index after the winner, wrapping at N_SRC (which need not be a power of two).
  assign win_next_ptr = (int'(win_idx) == N_SRC - 1) ? '0 : win_idx + 1'b1;

  // Owner still requesting, and whether its quantum has run out on this frame.
  assign own_req      = req[active_idx];
  assign quantum_done = (int'(fcnt) + 1 >= QUANTUM);

  // Arbitration FSM: decisions are taken only on frame_begin so no frame is ever torn.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      fcnt         <= '0;
      rr_ptr       <= '0;
      grant        <= '0;
      grant_valid  <= 1'b0;
      active_idx   <= '0;
      switch_pulse <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      if (frame_begin) begin
        case (state)
          IDLE: begin
            if (win_vld) begin
              state        <= HOLD;
              grant        <= {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
              grant_valid  <= 1'b1;
              active_idx   <= win_idx;
              fcnt         <= '0;
              rr_ptr       <= win_next_ptr;
              switch_pulse <= 1'b1;
            end
          end
          HOLD: begin
            if (!own_req || quantum_done) begin
              if (!win_vld) begin
                state        <= IDLE;
                grant        <= '0;
                grant_valid  <= 1'b0;
                active_idx   <= '0;
                fcnt         <= '0;
                switch_pulse <= 1'b1;
              end else if (win_idx != active_idx) begin
                grant        <= {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
                active_idx   <= win_idx;
                fcnt         <= '0;
                rr_ptr       <= win_next_ptr;
                switch_pulse <= 1'b1;
              end else begin
                // Nobody else wants the display: keep the owner, pin the counter.
                fcnt <= FW'(QUANTUM);
              end
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Registered select, combinational data path: the owner's pixel passes straight through.
  assign pixel_data = grant_valid ? src_pixel[16*active_idx +: 16] : BG_COLOUR;

endmodule
